// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight predictions in an in-order BTQ, checks them
// against resolved outcomes, trains the BPU and raises a one-cycle mispredict flush.
module branch_resolve_unit #(
    parameter int XLEN           = 32,
    parameter int PREDITOR_DEPTH = 64,
    parameter int BTQ_DEPTH      = 8
) (
    input  logic                              clock,
    input  logic                              resetn,
    input  logic                              fetchValid,
    input  logic [XLEN-1:0]                   fetchPC,
    input  logic                              predTaken,
    input  logic [XLEN-1:0]                   predTarget,
    input  logic [$clog2(PREDITOR_DEPTH)-1:0] predIndex,
    output logic                              btqFull,
    output logic                              btqEmpty,
    input  logic                              resolveValid,
    input  logic                              resolveTaken,
    input  logic [XLEN-1:0]                   resolveTarget,
    input  logic                              resolveType,
    input  logic                              flushIn,
    output logic                              preditorUpdate,
    output logic                              globalPreditorUpdate,
    output logic                              lastResult,
    output logic [$clog2(PREDITOR_DEPTH)-1:0] lastIndex,
    output logic                              btbUpdate,
    output logic                              branchType,
    output logic [XLEN-1:0]                   target,
    output logic [XLEN-1:0]                   branchAddr,
    output logic                              flush,
    output logic [XLEN-1:0]                   redirectPC,
    output logic [15:0]                       mispredictCount,
    output logic                              errOverflow,
    output logic                              errUnderflow
);

    localparam int IW = $clog2(PREDITOR_DEPTH);
    localparam int PW = $clog2(BTQ_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(BTQ_DEPTH);

    typedef enum logic {
        RUN,
        RECOVER
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_btqPC     [BTQ_DEPTH];
    logic            r_btqTaken  [BTQ_DEPTH];
    logic [XLEN-1:0] r_btqTarget [BTQ_DEPTH];
    logic [IW-1:0]   r_btqIndex  [BTQ_DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW:0]     r_count;

    logic            r_predUpd;
    logic            r_lastResult;
    logic [IW-1:0]   r_lastIndex;
    logic            r_btbUpd;
    logic            r_branchType;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_branchAddr;
    logic            r_flush;
    logic [XLEN-1:0] r_redirectPC;
    logic [15:0]     r_misCount;
    logic            r_errOverflow;
    logic            r_errUnderflow;

    logic            w_full;
    logic            w_empty;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_mis;
    logic [XLEN-1:0] w_headPC;
    logic            w_headTaken;
    logic [XLEN-1:0] w_headTarget;
    logic [IW-1:0]   w_headIndex;
    logic [XLEN-1:0] w_headPCPlus4;

    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == '0);
    // Nothing is accepted during the recovery cycle or under an external flush.
    assign w_accept = (r_state == RUN) && !flushIn;
    assign w_push   = w_accept && fetchValid && !w_full;
    assign w_pop    = w_accept && resolveValid && !w_empty;

    assign w_headPC      = r_btqPC[r_head];
    assign w_headTaken   = r_btqTaken[r_head];
    assign w_headTarget  = r_btqTarget[r_head];
    assign w_headIndex   = r_btqIndex[r_head];
    assign w_headPCPlus4 = w_headPC + XLEN'(4);

    assign w_mis = (resolveTaken != w_headTaken) ||
                   (resolveTaken && (resolveTarget != w_headTarget));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= RUN;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_predUpd      <= 1'b0;
            r_lastResult   <= 1'b0;
            r_lastIndex    <= '0;
            r_btbUpd       <= 1'b0;
            r_branchType   <= 1'b0;
            r_target       <= '0;
            r_branchAddr   <= '0;
            r_flush        <= 1'b0;
            r_redirectPC   <= '0;
            r_misCount     <= '0;
            r_errOverflow  <= 1'b0;
            r_errUnderflow <= 1'b0;
            for (int unsigned i = 0; i < BTQ_DEPTH; i++) begin
                r_btqPC[i]     <= '0;
                r_btqTaken[i]  <= 1'b0;
                r_btqTarget[i] <= '0;
                r_btqIndex[i]  <= '0;
            end
        end else begin
            r_predUpd <= 1'b0;
            r_btbUpd  <= 1'b0;
            r_flush   <= 1'b0;

            if (w_accept && fetchValid && w_full)
                r_errOverflow <= 1'b1;
            if (w_accept && resolveValid && w_empty)
                r_errUnderflow <= 1'b1;

            if (w_push) begin
                r_btqPC[r_tail]     <= fetchPC;
                r_btqTaken[r_tail]  <= predTaken;
                r_btqTarget[r_tail] <= predTarget;
                r_btqIndex[r_tail]  <= predIndex;
            end

            if (w_pop) begin
                r_predUpd    <= !resolveType;
                r_lastResult <= resolveTaken;
                r_lastIndex  <= w_headIndex;
                r_btbUpd     <= resolveTaken && w_mis;
                r_branchType <= resolveType;
                r_target     <= resolveTarget;
                r_branchAddr <= w_headPC;
                if (w_mis) begin
                    r_flush      <= 1'b1;
                    r_redirectPC <= resolveTaken ? resolveTarget : w_headPCPlus4;
                    r_misCount   <= r_misCount + 16'd1;
                end
            end

            // A mispredicting pop discards the whole queue, including any
            // same-cycle push, since everything younger is wrong-path.
            if (flushIn) begin
                r_state <= RUN;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else if (r_state == RECOVER) begin
                r_state <= RUN;
            end else if (w_pop && w_mis) begin
                r_state <= RECOVER;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_tail <= r_tail + PW'(1);
                if (w_pop)
                    r_head <= r_head + PW'(1);
                unique case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PW+1)'(1);
                    2'b01:   r_count <= r_count - (PW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign btqFull              = w_full;
    assign btqEmpty             = w_empty;
    assign preditorUpdate       = r_predUpd;
    assign globalPreditorUpdate = r_predUpd;
    assign lastResult           = r_lastResult;
    assign lastIndex            = r_lastIndex;
    assign btbUpdate            = r_btbUpd;
    assign branchType           = r_branchType;
    assign target               = r_target;
    assign branchAddr           = r_branchAddr;
    assign flush                = r_flush;
    assign redirectPC           = r_redirectPC;
    assign mispredictCount      = r_misCount;
    assign errOverflow          = r_errOverflow;
    assign errUnderflow         = r_errUnderflow;

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Commit-side counterpart of the branch prediction unit. It records every prediction fetch makes in an in-order branch tracking queue (BTQ), checks each against the outcome execute resolves, and drives the BPU training ports (predictor counter, GHR, BTB). On a mispredict it raises a one-cycle flush with the corrected PC for fetch and the BPU.

## Interface
- XLEN, 32, data/address width
- PREDITOR_DEPTH, 64, predictor entries; IW = $clog2(PREDITOR_DEPTH)
- BTQ_DEPTH, 8, in-flight branch entries, power of two; PW = $clog2(BTQ_DEPTH)

Ports:
- clock  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- fetchValid  in  1  fetch issued a control-flow instruction with a prediction
- fetchPC  in  XLEN  its PC
- predTaken  in  1  BPU branchTaken at fetch
- predTarget  in  XLEN  BPU branchTarget at fetch
- predIndex  in  IW  BPU preditorIndex at fetch
- btqFull  out  1  count == BTQ_DEPTH; fetch stalls on it
- btqEmpty  out  1  count == 0
- resolveValid  in  1  execute resolved the oldest outstanding branch (program order)
- resolveTaken  in  1  actual direction
- resolveTarget  in  XLEN  actual taken target
- resolveType  in  1  1 = unconditional, 0 = conditional
- flushIn  in  1  external pipeline flush (exception/trap)
- preditorUpdate  out  1  counter training strobe
- globalPreditorUpdate  out  1  GHR shift strobe
- lastResult  out  1  trained outcome
- lastIndex  out  IW  trained counter index
- btbUpdate  out  1  BTB write strobe
- branchType  out  1  BTB entry type
- target  out  XLEN  BTB entry target
- branchAddr  out  XLEN  PC of the branch being written
- flush  out  1  mispredict flush to fetch and BPU
- redirectPC  out  XLEN  corrected fetch PC, valid with flush
- mispredictCount  out  16  mispredict counter, wraps at 0xFFFF→0
- errOverflow  out  1  sticky: push while full
- errUnderflow  out  1  sticky: resolve while empty

## Operation
- The BTQ is a circular FIFO with head and tail pointers (PW bits, wrapping at BTQ_DEPTH) and a count register (PW+1 bits). Each entry holds {fetchPC, predTaken, predTarget, predIndex}.
- Push: fetchValid && count<BTQ_DEPTH && state==RUN && !flushIn. Write the entry at tail, then tail++.
  - A push while full is dropped and sets errOverflow. A simultaneous pop does not make room in that cycle.
- Pop: resolveValid && count>0 && state==RUN. Compare the result against the head entry, then head++.
  - A resolve while empty is ignored and sets errUnderflow.
- Simultaneous push and pop: count is unchanged. Both pointers advance.
- Mispredict for the popped entry: mis = (resolveTaken != predTaken) || (resolveTaken && resolveTarget != predTarget).
- Registered outputs for a pop at cycle N, valid in cycle N+1:
  - preditorUpdate = globalPreditorUpdate = !resolveType; lastResult = resolveTaken; lastIndex = predIndex.
  - btbUpdate = resolveTaken && mis; branchType = resolveType; target = resolveTarget; branchAddr = fetchPC.
  - On mis: flush = 1; redirectPC = resolveTaken ? resolveTarget : fetchPC + 4 (mod 2^XLEN); mispredictCount++.
- FSM states RUN and RECOVER:
  - RUN → RECOVER on a pop with mis. On that edge the BTQ is cleared (head = tail = count = 0), and any same-cycle push is discarded as wrong-path.
  - RECOVER lasts exactly one cycle, the cycle flush is high. fetchValid and resolveValid are ignored in it and raise no errors. RECOVER → RUN unconditionally.
- flushIn in any state: clears the BTQ and forces RUN next cycle. Same-cycle push and pop are discarded, and no training or flush output is produced for that cycle's resolve. flush is not asserted for flushIn.
- Error flags clear only on reset.

## Timing
- Reset values: all strobes, flush, redirectPC, lastResult, lastIndex, target, branchAddr, branchType, mispredictCount, and error flags are 0. btqEmpty = 1, btqFull = 0, state RUN, pointers and count 0.
- btqFull and btqEmpty come combinationally from the count register. They reflect pushes and pops of the previous edge.
- Update and flush strobes are high for exactly one cycle, N+1 after the resolving cycle N. Data outputs hold their values until the next pop.
- Back-to-back resolves in RUN are sustained at 1 per cycle.
- The first resolve accepted after a mispredict occurs no earlier than N+2.
- Reset asserted mid-operation clears all state immediately and asynchronously.

## Test plan
- Push PC 0x100 (predTaken=1, predTarget=0x200, predIndex=5); resolve taken to 0x200, conditional → N+1: preditorUpdate=1, globalPreditorUpdate=1, lastResult=1, lastIndex=5, btbUpdate=0, flush=0.
- Push PC 0x100 (predTaken=0, predIndex=9); resolve taken to 0x300, conditional → N+1: flush=1, redirectPC=0x300, btbUpdate=1, target=0x300, branchAddr=0x100, mispredictCount=1. In N+1, a resolveValid is ignored (errUnderflow stays 0); btqEmpty=1 at N+2.
- Push PC 0x40 (predTaken=1, predTarget=0x80); resolve not-taken → flush=1, redirectPC=0x44, btbUpdate=0.
- Unconditional jump, predTaken=1 to 0x500, resolved to 0x600 → preditorUpdate=0, btbUpdate=1, branchType=1, redirectPC=0x600.
- Push 8 entries → btqFull=1. A 9th push dropped → errOverflow=1. Push and pop in the same cycle while full → push dropped, count becomes 7. Then 7 in-order resolves with correct predictions cover pointer wrap: each training output carries its entry's predIndex in order.
- Resolve on an empty queue → errUnderflow=1, no strobes. flushIn with 3 entries queued → btqEmpty=1 next cycle, flush stays 0, no update strobes.
